// File: rtl/audio_sample_buffer.sv
// Single-clock frame buffer between core audio generators and the audio
// serializer. Frames are captured on value change or on a strobe, and one
// frame is released per serializer request. The buffer primes before
// releasing, and keeps sticky overflow/underflow flags.
module audio_sample_buffer #(
  parameter int WIDTH             = 16,
  parameter int CHANNELS          = 2,
  parameter int DEPTH_LOG2        = 2,
  parameter int WR_MODE           = 0,
  parameter int PRIME_LEVEL       = 2,
  parameter int UNDERFLOW_ZERO    = 0,
  parameter int OVERFLOW_DROP_OLD = 0
) (
  input  logic                        clk_sys,
  input  logic                        reset_n,
  input  logic [CHANNELS*WIDTH-1:0]   core_audio,
  input  logic                        core_valid,
  input  logic                        rd_tick,
  input  logic                        clear_flags,
  output logic [CHANNELS*WIDTH-1:0]   audio_out,
  output logic                        audio_valid,
  output logic [DEPTH_LOG2:0]         level,
  output logic                        empty,
  output logic                        full,
  output logic                        overflow,
  output logic                        underflow
);

  localparam int FW    = CHANNELS * WIDTH;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int LW    = DEPTH_LOG2 + 1;
  localparam logic [LW-1:0] LVL_FULL  = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_PRIME = LW'(PRIME_LEVEL);

  typedef enum logic {PRIME, RUN} state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [FW-1:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0]   wr_ptr;
  logic [DEPTH_LOG2-1:0]   rd_ptr;
  logic [FW-1:0]           prev;
  logic                    push;
  logic                    pop;
  logic                    wr_en;
  logic                    drop_old;
  logic                    overflow_set;
  logic                    underflow_set;
  logic [LW-1:0]           level_nxt;

  // In change-detect mode a frame differing from last cycle's input is a push.
  assign push = (WR_MODE != 0) ? core_valid : (core_audio != prev);

  // Read FSM decisions: priming, popping, and falling back to PRIME on underflow.
  always_comb begin
    state_nxt     = state;
    pop           = 1'b0;
    underflow_set = 1'b0;
    case (state)
      PRIME: begin
        if (level >= LVL_PRIME) state_nxt = RUN;
      end
      RUN: begin
        if (rd_tick) begin
          if (level != '0) begin
            pop = 1'b1;
          end else begin
            underflow_set = 1'b1;
            state_nxt     = PRIME;
          end
        end
      end
      default: state_nxt = PRIME;
    endcase
  end

  // Write acceptance and next fill level; a pop in the same cycle frees room.
  always_comb begin
    overflow_set = push && (level == LVL_FULL) && !pop;
    drop_old     = overflow_set && (OVERFLOW_DROP_OLD != 0);
    wr_en        = push && (!overflow_set || drop_old);
    level_nxt    = level;
    if (wr_en && !drop_old) level_nxt = level_nxt + LW'(1);
    if (pop)                level_nxt = level_nxt - LW'(1);
  end

  // FSM state register.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state <= PRIME;
    else          state <= state_nxt;
  end

  // Pointers, registered fill status and the change-detect reference frame.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      empty  <= 1'b0;
      full   <= 1'b0;
      prev   <= '0;
    end else begin
      if (wr_en)           wr_ptr <= wr_ptr + 1'b1;
      if (pop || drop_old) rd_ptr <= rd_ptr + 1'b1;
      level <= level_nxt;
      empty <= (level_nxt == '0);
      full  <= (level_nxt == LVL_FULL);
      prev  <= core_audio;
    end
  end

  // Frame storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk_sys) begin
    if (wr_en) mem[wr_ptr] <= core_audio;
  end

  // Output frame register: popped frame, or hold/zero when nothing is released.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      audio_out   <= '0;
      audio_valid <= 1'b0;
    end else begin
      audio_valid <= rd_tick;
      if (rd_tick) begin
        if (pop)                      audio_out <= mem[rd_ptr];
        else if (UNDERFLOW_ZERO != 0) audio_out <= '0;
      end
    end
  end

  // Sticky flags; a new event in the clearing cycle keeps the flag set.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= overflow_set  | (overflow  & ~clear_flags);
      underflow <= underflow_set | (underflow & ~clear_flags);
    end
  end

endmodule

// File: tb/tb_audio_sample_buffer.sv
// Bench for audio_sample_buffer: three configurations driven by shared inputs
// and compared every cycle against a list-based frame model.
module tb_audio_sample_buffer;

  logic        clk;
  logic        reset_n;
  logic [31:0] core_audio;
  logic        core_valid;
  logic        rd_tick;
  logic        clear_flags;

  logic [31:0] out_w [3];
  logic        vld_w [3];
  logic [2:0]  lvl_w [3];
  logic        emp_w [3];
  logic        ful_w [3];
  logic        ovf_w [3];
  logic        udf_w [3];

  int checks = 0;
  int errors = 0;

  // Per-instance configuration: write mode, underflow-zero, drop-old.
  int wrm  [3] = '{0, 1, 1};
  int uz   [3] = '{0, 1, 0};
  int dold [3] = '{0, 0, 1};

  // Reference model: ordered frame list per instance (index 0 = oldest).
  logic [31:0] m_q [3][4];
  int          m_cnt   [3];
  logic [31:0] m_prev  [3];
  logic [31:0] m_out   [3];
  logic        m_vld   [3];
  logic        m_run   [3];
  logic        m_of    [3];
  logic        m_uf    [3];
  logic        m_empty [3];
  logic        m_full  [3];

  logic [31:0] frames [10];

  audio_sample_buffer #(.WR_MODE(0), .UNDERFLOW_ZERO(0), .OVERFLOW_DROP_OLD(0)) dut0 (
    .clk_sys(clk), .reset_n(reset_n), .core_audio(core_audio), .core_valid(core_valid),
    .rd_tick(rd_tick), .clear_flags(clear_flags), .audio_out(out_w[0]), .audio_valid(vld_w[0]),
    .level(lvl_w[0]), .empty(emp_w[0]), .full(ful_w[0]), .overflow(ovf_w[0]), .underflow(udf_w[0]));

  audio_sample_buffer #(.WR_MODE(1), .UNDERFLOW_ZERO(1), .OVERFLOW_DROP_OLD(0)) dut1 (
    .clk_sys(clk), .reset_n(reset_n), .core_audio(core_audio), .core_valid(core_valid),
    .rd_tick(rd_tick), .clear_flags(clear_flags), .audio_out(out_w[1]), .audio_valid(vld_w[1]),
    .level(lvl_w[1]), .empty(emp_w[1]), .full(ful_w[1]), .overflow(ovf_w[1]), .underflow(udf_w[1]));

  audio_sample_buffer #(.WR_MODE(1), .UNDERFLOW_ZERO(0), .OVERFLOW_DROP_OLD(1)) dut2 (
    .clk_sys(clk), .reset_n(reset_n), .core_audio(core_audio), .core_valid(core_valid),
    .rd_tick(rd_tick), .clear_flags(clear_flags), .audio_out(out_w[2]), .audio_valid(vld_w[2]),
    .level(lvl_w[2]), .empty(emp_w[2]), .full(ful_w[2]), .overflow(ovf_w[2]), .underflow(udf_w[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_cnt[k]   = 0;
      m_prev[k]  = '0;
      m_out[k]   = '0;
      m_vld[k]   = 1'b0;
      m_run[k]   = 1'b0;
      m_of[k]    = 1'b0;
      m_uf[k]    = 1'b0;
      m_empty[k] = 1'b0;
      m_full[k]  = 1'b0;
    end
  endtask

  task automatic drop_front(input int k);
    for (int i = 0; i < 3; i++) m_q[k][i] = m_q[k][i+1];
    m_cnt[k]--;
  endtask

  task automatic append(input int k, input logic [31:0] v);
    m_q[k][m_cnt[k]] = v;
    m_cnt[k]++;
  endtask

  // One clock edge of the model, using the inputs as they stood before the edge.
  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      int c;
      bit push, pop, uf_set, of_set;
      c      = m_cnt[k];
      push   = (wrm[k] != 0) ? core_valid : (core_audio != m_prev[k]);
      m_prev[k] = core_audio;
      pop    = rd_tick && m_run[k] && (c > 0);
      uf_set = rd_tick && m_run[k] && (c == 0);
      of_set = push && (c == 4) && !pop;
      m_vld[k] = rd_tick;
      if (rd_tick) begin
        if (pop)             m_out[k] = m_q[k][0];
        else if (uz[k] != 0) m_out[k] = '0;
      end
      if (pop) drop_front(k);
      if (push) begin
        if (m_cnt[k] < 4) append(k, core_audio);
        else if (dold[k] != 0) begin
          drop_front(k);
          append(k, core_audio);
        end
      end
      if (!m_run[k])                m_run[k] = (c >= 2);
      else if (rd_tick && (c == 0)) m_run[k] = 1'b0;
      m_of[k]    = of_set | (m_of[k] & ~clear_flags);
      m_uf[k]    = uf_set | (m_uf[k] & ~clear_flags);
      m_empty[k] = (m_cnt[k] == 0);
      m_full[k]  = (m_cnt[k] == 4);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("d%0d_out", k),   64'(out_w[k]), 64'(m_out[k]));
      chk($sformatf("d%0d_vld", k),   64'(vld_w[k]), 64'(m_vld[k]));
      chk($sformatf("d%0d_level", k), 64'(lvl_w[k]), 64'(m_cnt[k]));
      chk($sformatf("d%0d_empty", k), 64'(emp_w[k]), 64'(m_empty[k]));
      chk($sformatf("d%0d_full", k),  64'(ful_w[k]), 64'(m_full[k]));
      chk($sformatf("d%0d_ovf", k),   64'(ovf_w[k]), 64'(m_of[k]));
      chk($sformatf("d%0d_udf", k),   64'(udf_w[k]), 64'(m_uf[k]));
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (reset_n) model_step();
    else         model_reset();
    #1;
    check_all();
  endtask

  initial begin
    frames = '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003, 32'hDDDD_0004, 32'hEEEE_0005,
               32'h1F1F_0006, 32'h2F2F_0007, 32'h3F3F_0008, 32'h4F4F_0009, 32'h5F5F_000A};
    reset_n = 1'b0; core_audio = '0; core_valid = 1'b0; rd_tick = 1'b0; clear_flags = 1'b0;
    model_reset();
    step();
    step();
    chk("reset_out", 64'(out_w[0]), 64'h0);
    chk("reset_level", 64'(lvl_w[0]), 64'h0);
    reset_n = 1'b1;

    // Defaults: two changes push two frames, then the first read returns the first.
    core_audio = 32'h1111_2222; step();
    core_audio = 32'h3333_4444; step();
    chk("t1_level2", 64'(lvl_w[0]), 64'd2);
    step();
    rd_tick = 1'b1; step(); rd_tick = 1'b0;
    chk("t1_out", 64'(out_w[0]), 64'h1111_2222);
    chk("t1_vld", 64'(vld_w[0]), 64'h1);
    chk("t1_level1", 64'(lvl_w[0]), 64'd1);

    // Underflow: drain, then one more request while running.
    rd_tick = 1'b1; step();
    chk("t3_pop_b", 64'(out_w[0]), 64'h3333_4444);
    step(); rd_tick = 1'b0;
    chk("t3_udf", 64'(udf_w[0]), 64'h1);
    chk("t3_hold", 64'(out_w[0]), 64'h3333_4444);
    chk("t3_zero", 64'(out_w[1]), 64'h0);
    clear_flags = 1'b1; step(); clear_flags = 1'b0;
    chk("t3_clear", 64'(udf_w[0]), 64'h0);

    // Prime: one frame stored is not enough to release anything.
    core_audio = 32'h5555_6666; step();
    rd_tick = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t2_vld", 64'(vld_w[0]), 64'h1);
      chk("t2_hold", 64'(out_w[0]), 64'h3333_4444);
      chk("t2_udf", 64'(udf_w[0]), 64'h0);
      chk("t2_level", 64'(lvl_w[0]), 64'd1);
    end
    rd_tick = 1'b0; step();

    reset_n = 1'b0; step(); step(); reset_n = 1'b1;

    // Overflow: five strobed pushes into four slots, then four reads.
    core_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      core_audio = frames[i];
      step();
      if (i == 3) begin
        chk("t4_full1", 64'(ful_w[1]), 64'h1);
        chk("t4_full2", 64'(ful_w[2]), 64'h1);
      end
    end
    core_valid = 1'b0;
    chk("t4_ovf1", 64'(ovf_w[1]), 64'h1);
    chk("t5_ovf2", 64'(ovf_w[2]), 64'h1);
    chk("t5_level", 64'(lvl_w[2]), 64'd4);
    rd_tick = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t4_read", 64'(out_w[1]), 64'(frames[i]));
      chk("t5_read", 64'(out_w[2]), 64'(frames[i+1]));
    end
    rd_tick = 1'b0;

    // Concurrency: full buffer, push and pop together.
    clear_flags = 1'b1; core_valid = 1'b1;
    for (int i = 5; i < 9; i++) begin
      core_audio = frames[i];
      step();
      clear_flags = 1'b0;
    end
    core_audio = frames[9]; rd_tick = 1'b1; step();
    chk("t6_noovf", 64'(ovf_w[1]), 64'h0);
    chk("t6_level", 64'(lvl_w[1]), 64'd4);
    chk("t6_out", 64'(out_w[1]), 64'(frames[5]));
    chk("t6_out2", 64'(out_w[2]), 64'(frames[5]));

    // Reset in mid-stream: outputs clear without waiting for an edge.
    core_audio = 32'h7777_8888;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("t6_async_out", 64'(out_w[2]), 64'h0);
    step(); step();
    rd_tick = 1'b0; core_valid = 1'b0; core_audio = '0;
    reset_n = 1'b1;
    step();
    chk("t6_lvl0", 64'(lvl_w[1]), 64'd0);
    chk("t6_empty", 64'(emp_w[1]), 64'h1);
    core_valid = 1'b1; core_audio = 32'h9999_0000; step(); core_valid = 1'b0;
    rd_tick = 1'b1; step(); rd_tick = 1'b0;
    chk("t6_prime_out", 64'(out_w[1]), 64'h0);
    chk("t6_prime_lvl", 64'(lvl_w[1]), 64'd1);

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      core_audio  = frames[$urandom_range(0, 3)];
      core_valid  = 1'($urandom_range(0, 1));
      rd_tick     = ($urandom_range(0, 2) == 0);
      clear_flags = ($urandom_range(0, 15) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
